// File: rtl/systolic_tile_scheduler.sv
// ---------------------------------------------------------------------------
// systolic_tile_scheduler
//
// This block is the upstream sequencer for the systolic array's valid pipeline
// controller. It accepts a tile command from the host. For each tile it reads
// ROWS operand words from the operand buffer and then fires a one-cycle
// loading_start. It waits for pipe_busy to drain before it starts the next
// tile, and it pulses done after the last tile.
//
// Optional feature macro: SCHED_TIMEOUT_EN
//   When defined, a drain watchdog is added. If pipe_busy is still high after
//   TIMEOUT cycles in DRAIN, err is pulsed and the scheduler returns to IDLE.
//   When not defined, DRAIN waits indefinitely and err is tied to 0.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   cmd_valid      in   host command valid
//   cmd_ready      out  command can be accepted (high only in IDLE)
//   cmd_base       in   buffer base address of the first tile
//   cmd_num_tiles  in   number of tiles to run (0 is legal)
//   buf_rd_en      out  operand buffer read strobe
//   buf_rd_addr    out  operand buffer read address
//   loading_start  out  one-cycle pulse to the valid pipeline controller
//   pipe_busy      in   busy from the valid pipeline controller
//   tile_idx       out  index of the tile in progress
//   done           out  one-cycle pulse when a command completes
//   err            out  one-cycle pulse on drain timeout
//   state_dbg      out  current FSM state, for observation only
//
// Handshake: a command transfers on a rising edge where cmd_valid and
// cmd_ready are both high. cmd_ready depends only on state, never on
// cmd_valid. cmd_valid is ignored whenever cmd_ready is low.
// ---------------------------------------------------------------------------
module systolic_tile_scheduler #(
    parameter int ROWS    = 2,
    parameter int ADDR_W  = 8,
    parameter int TILE_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDR_W-1:0] cmd_base,
    input  logic [TILE_W-1:0] cmd_num_tiles,
    output logic              buf_rd_en,
    output logic [ADDR_W-1:0] buf_rd_addr,
    output logic              loading_start,
    input  logic              pipe_busy,
    output logic [TILE_W-1:0] tile_idx,
    output logic              done,
    output logic              err,
    output logic [2:0]        state_dbg
);

    if (ROWS < 1 || TIMEOUT < 1) begin : g_param_check
        $error("systolic_tile_scheduler: ROWS and TIMEOUT must be >= 1");
    end

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FIRE  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [TILE_W-1:0] tile_q;
    logic [TILE_W-1:0] last_tile_q;
    logic [ROW_W-1:0]  row_q;
    logic              drain_first_q;

`ifdef SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] drain_cnt_q;
    logic             err_q;
    logic             timeout_hit;
`endif

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
`ifdef SCHED_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = (cmd_num_tiles == '0) ? S_DONE : S_LOAD;
                end
            end
            S_LOAD: begin
                if (row_q == ROW_LAST) begin
                    state_d = S_FIRE;
                end
            end
            S_FIRE: state_d = S_DRAIN;
            S_DRAIN: begin
                // The controller's busy lags loading_start by one cycle. For that
                // reason the first DRAIN cycle cannot be used to decide an exit.
                if (!drain_first_q && !pipe_busy) begin
                    state_d = (tile_q == last_tile_q) ? S_DONE : S_LOAD;
                end
`ifdef SCHED_TIMEOUT_EN
                else if (pipe_busy && drain_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = S_IDLE;
                    timeout_hit = 1'b1;
                end
`endif
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- datapath ----------------
    // addr_q is a running read pointer. It is loaded with base on accept and
    // stepped once per LOAD cycle. Tiles are contiguous, so this pointer always
    // equals base + tile*ROWS + row (mod 2^ADDR_W).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q        <= '0;
            tile_q        <= '0;
            last_tile_q   <= '0;
            row_q         <= '0;
            drain_first_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        addr_q      <= cmd_base;
                        tile_q      <= '0;
                        row_q       <= '0;
                        last_tile_q <= cmd_num_tiles - TILE_W'(1);
                    end
                end
                S_LOAD: begin
                    addr_q <= addr_q + ADDR_W'(1);
                    row_q  <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end
                S_FIRE: begin
                    drain_first_q <= 1'b1;
                end
                S_DRAIN: begin
                    drain_first_q <= 1'b0;
                    if (state_d == S_LOAD) begin
                        tile_q <= tile_q + TILE_W'(1);
                        row_q  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SCHED_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt_q <= '0;
            err_q       <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state_q == S_DRAIN) begin
                drain_cnt_q <= drain_cnt_q + CNT_W'(1);
            end else begin
                drain_cnt_q <= '0;
            end
        end
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // ---------------- outputs (decoded state / flops only) ----------------
    assign cmd_ready     = (state_q == S_IDLE);
    assign buf_rd_en     = (state_q == S_LOAD);
    assign loading_start = (state_q == S_FIRE);
    assign done          = (state_q == S_DONE);
    assign buf_rd_addr   = addr_q;
    assign tile_idx      = tile_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// ---------------------------------------------------------------------------
// tb_systolic_tile_scheduler
//
// This is the testbench for systolic_tile_scheduler. For every command it
// issues, the stimulus computes the full expected event schedule from the
// block's latency rules:
//   - reads happen on cycles L..L+ROWS-1;
//   - loading_start happens at L+ROWS;
//   - the next tile or done comes at L+ROWS+k+2.
// It queues this schedule in cycle order. A monitor pops the queue and compares
// it against the DUT strobes every cycle. The monitor also models the pipeline:
// busy goes high for k cycles, starting one cycle after each loading_start.
// ---------------------------------------------------------------------------
module tb_systolic_tile_scheduler;
    localparam int ROWS    = 2;
    localparam int ADDR_W  = 8;
    localparam int TILE_W  = 4;
    localparam int TIMEOUT = 16;
`ifdef SCHED_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    localparam int K_NONE = 0, K_RD = 1, K_LS = 2, K_DONE = 3, K_ERR = 4;

    typedef struct packed {
        logic [31:0]       c;
        logic [2:0]        kind;
        logic [ADDR_W-1:0] a;
        logic [TILE_W-1:0] t;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [TILE_W-1:0] cmd_num_tiles = '0;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;
    logic              loading_start;
    logic              pipe_busy = 1'b0;
    logic [TILE_W-1:0] tile_idx;
    logic              done;
    logic              err;
    logic [2:0]        state_dbg;

    ev_t exp_q[$];
    int  k_q[$];
    int  cyc = 0;
    int  win_lo = -1;
    int  win_hi = -1;
    int  busy_left = 0;
    int  vectors = 0;
    int  miscompares = 0;

    systolic_tile_scheduler #(
        .ROWS(ROWS), .ADDR_W(ADDR_W), .TILE_W(TILE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_base(cmd_base), .cmd_num_tiles(cmd_num_tiles),
        .buf_rd_en(buf_rd_en), .buf_rd_addr(buf_rd_addr),
        .loading_start(loading_start), .pipe_busy(pipe_busy),
        .tile_idx(tile_idx), .done(done), .err(err),
        .state_dbg(state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string nm, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input int c, input int kind, input logic [ADDR_W-1:0] a, input int t);
        ev_t e;
        e.c    = c;
        e.kind = 3'(kind);
        e.a    = a;
        e.t    = TILE_W'(t);
        exp_q.push_back(e);
    endtask

    // Issue one command and queue its expected schedule.
    // If kfix > 0, it is the busy length for every tile; otherwise each tile
    // gets a random busy length.
    task automatic issue(input logic [ADDR_W-1:0] base, input int n, input int kfix, input int gap);
        int l, k, acc, end_c;
        logic [ADDR_W-1:0] a;
        while (cyc <= win_hi) next_cycle();
        repeat (gap) next_cycle();
        cmd_valid     = 1'b1;
        cmd_base      = base;
        cmd_num_tiles = TILE_W'(n);
        acc   = cyc;
        a     = base;
        l     = acc + 1;
        end_c = acc + 1;
        if (n == 0) begin
            push_ev(acc + 1, K_DONE, '0, 0);
        end else begin
            for (int t = 0; t < n; t++) begin
                k = (kfix > 0) ? kfix : int'($urandom_range(1, 5));
                for (int r = 0; r < ROWS; r++) begin
                    push_ev(l + r, K_RD, a, t);
                    a = a + ADDR_W'(1);
                end
                push_ev(l + ROWS, K_LS, '0, t);
                k_q.push_back(k);
                if (TIMEOUT_ON && k >= TIMEOUT) begin
                    push_ev(l + ROWS + 1 + TIMEOUT, K_ERR, '0, t);
                    end_c = l + ROWS + TIMEOUT;
                    break;
                end
                end_c = l + ROWS + k + 2;
                if (t == n - 1) push_ev(end_c, K_DONE, '0, t);
                l = end_c;
            end
        end
        win_lo = acc;
        win_hi = end_c;
        // Keep cmd_valid high with junk for one cycle; it must be ignored.
        next_cycle();
        cmd_base      = ADDR_W'($urandom);
        cmd_num_tiles = TILE_W'($urandom);
        next_cycle();
        cmd_valid = 1'b0;
    endtask

    // ---------------- monitor + pipeline model ----------------
    initial begin
        ev_t e;
        int  exp_kind, obs;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst_n) begin
                exp_q.delete();
                k_q.delete();
                busy_left = 0;
                pipe_busy = 1'b0;
            end else begin
                pipe_busy = (busy_left > 0);
                if (busy_left > 0) busy_left--;
                exp_kind = K_NONE;
                e = '0;
                if (exp_q.size() > 0 && int'(exp_q[0].c) == cyc) begin
                    e = exp_q.pop_front();
                    exp_kind = int'(e.kind);
                end
                obs = buf_rd_en ? K_RD : loading_start ? K_LS : done ? K_DONE : err ? K_ERR : K_NONE;
                check("strobe_kind", obs, exp_kind);
                check("strobe_count", $countones({buf_rd_en, loading_start, done, err}),
                      (exp_kind != K_NONE) ? 1 : 0);
                if (exp_kind == K_RD && obs == K_RD) begin
                    check("rd_addr", int'(buf_rd_addr), int'(e.a));
                    check("rd_tile", int'(tile_idx), int'(e.t));
                end
                if (exp_kind == K_LS && obs == K_LS) check("ls_tile", int'(tile_idx), int'(e.t));
                if (exp_kind == K_DONE && obs == K_DONE) check("done_tile", int'(tile_idx), int'(e.t));
                if (exp_kind == K_ERR && obs == K_ERR) check("err_tile", int'(tile_idx), int'(e.t));
                if (loading_start && k_q.size() > 0) busy_left = k_q.pop_front();
                check("cmd_ready", int'(cmd_ready), (cyc > win_lo && cyc <= win_hi) ? 0 : 1);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int tgt;
        logic [ADDR_W-1:0] rbase;
        repeat (3) next_cycle();
        // reset state
        check("rst_cmd_ready", int'(cmd_ready), 1);
        check("rst_rd_en", int'(buf_rd_en), 0);
        check("rst_rd_addr", int'(buf_rd_addr), 0);
        check("rst_ls", int'(loading_start), 0);
        check("rst_tile", int'(tile_idx), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst_n = 1'b1;
        next_cycle();

        issue(8'h10, 1, 3, 0);                 // single tile, busy 3 cycles
        issue(8'h20, 3, 3, 0);                 // three tiles back-to-back
        issue(ADDR_W'($urandom), 0, 0, 0);     // zero tiles
        issue(8'hFE, 2, 0, 0);                 // address wrap

        // reset during DRAIN of tile 1 of 3
        rbase = ADDR_W'($urandom);
        issue(rbase, 3, 4, 1);
        tgt = win_lo + 1 + (ROWS + 4 + 2) + ROWS + 2;
        while (cyc < tgt) next_cycle();
        #3;
        rst_n = 1'b0;
        win_lo = -1;
        win_hi = -1;
        #1;
        check("arst_cmd_ready", int'(cmd_ready), 1);
        check("arst_rd_en", int'(buf_rd_en), 0);
        check("arst_rd_addr", int'(buf_rd_addr), 0);
        check("arst_ls", int'(loading_start), 0);
        check("arst_tile", int'(tile_idx), 0);
        check("arst_done", int'(done), 0);
        check("arst_err", int'(err), 0);
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        issue(8'h40, 2, 0, 1);

        for (int i = 0; i < 12; i++) begin
            issue(ADDR_W'($urandom), int'($urandom_range(0, 4)), 0, int'($urandom_range(0, 3)));
        end

        // long busy: waits in DRAIN, or times out when the watchdog is built in
        issue(ADDR_W'($urandom), 1, 40, 0);

        for (int i = 0; i < 200 && exp_q.size() > 0; i++) next_cycle();
        check("exp_q_drained", exp_q.size(), 0);
        repeat (4) next_cycle();
        check("idle_cmd_ready", int'(cmd_ready), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // ---------------- global watchdog ----------------
    initial begin
        #500000;
        miscompares++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
